pwm_sequencer: RTL and testbench

//  Drives one PWM output through a programmable table of steps. Each step is
//  {high_time, repeat_count}. Fixed period of CNT_MAX clocks; duty changes only
//  at period boundaries, so the output never glitches mid-period.

---
 rtl/pwm_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pwm_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sequencer.sv
// pwm_sequencer
//   Plays one PWM output through a small table of {high_time, repeat_count}
//   steps. The period is fixed at CNT_MAX clocks. Duty changes happen only at
//   period boundaries, so a period is never cut short or changed partway.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous reset, active low
//   cfg_we    table write strobe (accepted in any state, one entry per cycle)
//   cfg_addr  table entry index
//   cfg_hi    high time in clocks; 0 = always low, >= CNT_MAX = always high
//   cfg_reps  periods to play the entry; 0 marks the end of the sequence
//   start     1-cycle pulse, starts at step 0 (accepted only when idle)
//   stop      1-cycle pulse, immediate abort; beats start in the same cycle
//   loop      sampled on an accepted start; 1 = wrap to step 0 at the end
//   busy      high while running
//   done      1-cycle pulse when the sequence ends on its own
//   step_idx  index of the step now playing
//   out       registered PWM output
module pwm_sequencer #(
  parameter int unsigned CLK_MHZ  = 50,
  parameter int unsigned FREQ_KHZ = 400,
  parameter int unsigned STEPS    = 4,
  parameter int unsigned RPT_W    = 8,
  localparam int unsigned CNT_MAX = 1000 * CLK_MHZ / FREQ_KHZ,
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1),
  localparam int unsigned AW      = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CNT_W-1:0] cfg_hi,
  input  logic [RPT_W-1:0] cfg_reps,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx,
  output logic             out
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [AW:0]      STEPS_L  = (AW + 1)'(STEPS);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [RPT_W-1:0] rep_q, rep_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;
  logic             out_q, out_d;

  logic [CNT_W-1:0] tbl_hi_q   [STEPS];
  logic [RPT_W-1:0] tbl_reps_q [STEPS];

  // One bit wider than the index so that "past the last entry" is visible.
  logic [AW:0] nxt;
  logic        nxt_end;

  assign nxt     = {1'b0, idx_q} + (AW + 1)'(1);
  assign nxt_end = (nxt == STEPS_L) || (tbl_reps_q[nxt[AW-1:0]] == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          loop_d = loop;
          if (tbl_reps_q[0] == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            idx_d   = '0;
            rep_d   = tbl_reps_q[0];
            hi_d    = tbl_hi_q[0];
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          // A zero repeat count can only appear if entry 0 was rewritten to
          // the end marker while looping; it is treated as a single period.
          if (rep_q > RPT_W'(1)) begin
            rep_d = rep_q - RPT_W'(1);
          end else if (!nxt_end) begin
            idx_d = nxt[AW-1:0];
            rep_d = tbl_reps_q[nxt[AW-1:0]];
            hi_d  = tbl_hi_q[nxt[AW-1:0]];
          end else if (loop_q) begin
            idx_d = '0;
            rep_d = tbl_reps_q[0];
            hi_d  = tbl_hi_q[0];
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output is computed from next-state values so the registered pin lines
    // up with the counter value of the same cycle.
    out_d = (state_d == ST_RUN) && (cnt_d < hi_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= 1'b0;
      tbl_hi_q   <= '{default: '0};
      tbl_reps_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      out_q   <= out_d;
      if (cfg_we) begin
        tbl_hi_q[cfg_addr]   <= cfg_hi;
        tbl_reps_q[cfg_addr] <= cfg_reps;
      end
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign step_idx = idx_q;
  assign out      = out_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
module tb_pwm_sequencer;
  localparam int unsigned STEPS = 4;
  localparam int CNT_MAX = 125;
  localparam int CNT_W   = 7;
  localparam int AW      = 2;
  localparam int RPT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [CNT_W-1:0] cfg_hi = '0;
  logic [RPT_W-1:0] cfg_reps = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop = 1'b0;
  logic             busy, done, out;
  logic [AW-1:0]    step_idx;

  pwm_sequencer #(.CLK_MHZ(50), .FREQ_KHZ(400), .STEPS(STEPS), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_hi(cfg_hi),
    .cfg_reps(cfg_reps), .start(start), .stop(stop), .loop(loop), .busy(busy),
    .done(done), .step_idx(step_idx), .out(out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sequence position expressed as step / periods left /
  // position inside the period, advanced once per clock from the bench inputs.
  int m_hi_tbl [STEPS];
  int m_rep_tbl[STEPS];
  bit m_run, m_loop, m_done;
  int m_pos, m_step, m_left, m_hi;

  task automatic m_load(input int s);
    m_step = s;
    m_left = m_rep_tbl[s];
    m_hi   = m_hi_tbl[s];
    m_pos  = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_loop = 0;
      m_pos = 0; m_step = 0; m_left = 0; m_hi = 0;
      foreach (m_hi_tbl[i]) begin
        m_hi_tbl[i] = 0;
        m_rep_tbl[i] = 0;
      end
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_loop = loop;
          if (m_rep_tbl[0] == 0) m_done = 1;
          else begin
            m_run = 1;
            m_load(0);
          end
        end
      end else if (stop) begin
        m_run = 0;
      end else if (m_pos < CNT_MAX - 1) begin
        m_pos++;
      end else if (m_left > 1) begin
        m_left--;
        m_pos = 0;
      end else if (m_step + 1 < STEPS && m_rep_tbl[m_step + 1] != 0) begin
        m_load(m_step + 1);
      end else if (m_loop) begin
        m_load(0);
      end else begin
        m_run = 0;
        m_done = 1;
      end
      if (cfg_we) begin
        m_hi_tbl[cfg_addr]  = int'(cfg_hi);
        m_rep_tbl[cfg_addr] = int'(cfg_reps);
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("out", int'(out), int'(m_run && (m_pos < m_hi)));
      chk("busy_and_done", int'(busy && done), 0);
      if (m_run) chk("step_idx", int'(step_idx), m_step);
    end
  end

  bit ob_out [700];
  int ob_step[700];
  int hi_cnt, busy_cnt, done_cnt, done_at;

  // Record n cycles of DUT outputs; optionally write a table entry at cycle wr_at.
  task automatic measure(input int n, input int wr_at = 0, input int wa = 0,
                         input int wh = 0, input int wrp = 0);
    hi_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      ob_out[i]  = out;
      ob_step[i] = int'(step_idx);
      if (out) hi_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      if (i == wr_at) begin
        cfg_we = 1'b1; cfg_addr = AW'(wa); cfg_hi = CNT_W'(wh); cfg_reps = RPT_W'(wrp);
      end else begin
        cfg_we = 1'b0;
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic wr(input int a, input int h, input int r);
    @(posedge clk); #2;
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_hi = CNT_W'(h); cfg_reps = RPT_W'(r);
    @(posedge clk); #2;
    cfg_we = 1'b0;
  endtask

  // Returns inside the first cycle after the start has been sampled.
  task automatic go(input bit lp, input bit st = 1'b0);
    @(posedge clk); #2;
    start = 1'b1; stop = st; loop = lp;
    @(posedge clk); #2;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk); #2;
    stop = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("reset_out", int'(out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_step", int'(step_idx), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: two periods of 50 high, then natural end
    wr(0, 50, 2); wr(1, 0, 0);
    go(0);
    measure(260);
    chk("t1_high", hi_cnt, 100);
    chk("t1_busy", busy_cnt, 250);
    chk("t1_done_at", done_at, 251);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: step change at the period boundary with no gap
    wr(0, 25, 1); wr(1, 100, 1); wr(2, 0, 0);
    go(0);
    measure(255);
    chk("t2_high", hi_cnt, 125);
    chk("t2_done_at", done_at, 251);
    chk("t2_step_p1", ob_step[125], 0);
    chk("t2_step_p2", ob_step[126], 1);
    chk("t2_out_c25", int'(ob_out[25]), 1);
    chk("t2_out_c26", int'(ob_out[26]), 0);
    chk("t2_out_p2", int'(ob_out[126]), 1);

    // 3: duty boundaries and a full table
    wr(1, 0, 0);
    wr(0, 0, 1);
    go(0); measure(130);
    chk("t3_hi0", hi_cnt, 0);
    chk("t3_hi0_done", done_at, 126);
    wr(0, 125, 1);
    go(0); measure(130);
    chk("t3_himax", hi_cnt, 125);
    wr(0, 127, 1);
    go(0); measure(130);
    chk("t3_hiover", hi_cnt, 125);
    wr(0, 10, 1); wr(1, 20, 1); wr(2, 30, 1); wr(3, 40, 1);
    go(0); measure(505);
    chk("t3_full_done", done_at, 501);
    chk("t3_full_high", hi_cnt, 100);
    chk("t3_full_step", ob_step[376], 3);

    // 4: looping, then stop at cnt==60
    wr(0, 10, 1); wr(1, 0, 0);
    go(1);
    measure(436);
    chk("t4_high", hi_cnt, 40);
    chk("t4_busy", busy_cnt, 436);
    chk("t4_nodone", done_cnt, 0);
    do_stop();
    chk("t4_stop_out", int'(out), 0);
    chk("t4_stop_busy", int'(busy), 0);
    chk("t4_stop_done", int'(done), 0);
    measure(5);
    chk("t4_after_done", done_cnt, 0);

    // 5: rewrite the playing entry mid-step
    wr(0, 40, 3);
    go(1);
    measure(625, 150, 0, 90, 1);
    chk("t5_high", hi_cnt, 300);
    chk("t5_old_c39", int'(ob_out[290]), 1);
    chk("t5_old_c40", int'(ob_out[291]), 0);
    chk("t5_new_c40", int'(ob_out[416]), 1);
    do_stop();

    // 6: async reset mid-period, then cleared table and start/stop rules
    wr(0, 100, 1); wr(1, 100, 1); wr(2, 0, 0);
    go(0);
    measure(130);
    chk("t6_pre_out", int'(ob_out[130]), 1);
    chk("t6_pre_step", ob_step[130], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", int'(out), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_step", int'(step_idx), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    go(0);
    measure(5);
    chk("t6_empty_done_at", done_at, 1);
    chk("t6_empty_busy", busy_cnt, 0);

    wr(0, 50, 1);
    go(0);
    measure(10);
    go(0);
    measure(120);
    chk("t6_rerun_done_at", done_at, 115);
    chk("t6_rerun_busy", busy_cnt, 114);

    go(0);
    measure(5);
    go(0, 1'b1);
    chk("t6_ss_run_busy", int'(busy), 0);
    chk("t6_ss_run_done", int'(done), 0);
    measure(130);
    chk("t6_ss_run_after", busy_cnt + done_cnt, 0);

    go(0, 1'b1);
    measure(130);
    chk("t6_ss_idle", busy_cnt + done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
